mfp_seven_segment_scanner: RTL and testbench
============================================

Name: mfp_seven_segment_scanner

Overview:
Parametrised, time-multiplexed driver for N common-anode seven-segment digits with decimal points.
Replaces the tied-off CA..CG/DP/AN outputs on the board top level; it is driven from a memory-mapped GPIO register pair in mfp_system.
Adds per-digit blanking, anti-ghosting blank time, and tear-free frame-synchronous updates through a load/pending shadow register.

Parameters:
N_DIGITS, 8, number of digits scanned (1..16)
SCAN_DIV, 100000, clock cycles per digit slot (>= 2)
BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off (0 <= BLANK_CYCLES < SCAN_DIV)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
number  in  4*N_DIGITS  hex nibble per digit; digit k = number[4k+3:4k]
dot_en  in  N_DIGITS  decimal point on, per digit
digit_en  in  N_DIGITS  digit visible, per digit (0 = blanked)
load  in  1  one-cycle strobe; captures number/dot_en/digit_en into pending
pending  out  1  1 while a captured value is waiting for the next frame boundary
frame_done  out  1  one-cycle pulse after each full scan of all digits
segments  out  7  active-low segments, bit0=a ... bit6=g
dp  out  1  active-low decimal point
anodes  out  N_DIGITS  active-low digit selects, at most one low at any time

Behaviour:
- Reset (async, rst=1): anodes all 1, segments 7'h7F, dp 1, frame_done 0, pending 0. Prescaler p=0, index idx=0. Active and pending shadow registers are cleared, so the display stays blank until the first load is applied.
- p counts 0..SCAN_DIV-1 and wraps to 0. When p==SCAN_DIV-1, idx advances and wraps from N_DIGITS-1 to 0.
- Frame boundary is the cycle with p==SCAN_DIV-1 and idx==N_DIGITS-1. With N_DIGITS=1, every slot end is a frame boundary.
- All outputs are registered, one-cycle latency from (p, idx, active):
  - anodes[idx]=0 iff p>=BLANK_CYCLES and active digit_en[idx]=1; all other anode bits are 1.
  - segments = hex7(active nibble[idx]) when that digit is lit, else 7'h7F.
  - dp = ~active dot_en[idx] when the digit is lit, else 1.
- hex7 encoding (active-low, g..a): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- load=1: pending_regs take the current inputs and pending goes to 1. A second load before the boundary overwrites pending_regs (latest wins).
- At a frame boundary with pending=1: active takes pending_regs and pending clears. The first slot of the new frame shows the new data.
- load in the same cycle as a frame boundary: the old pending value (if any) goes to active; the new value is captured into pending, which stays 1 and is applied at the next boundary.
- frame_done is 1 in the cycle after each frame boundary.
- rst asserted mid-frame returns to the reset state immediately and discards both active and pending values.

Decomposition:
- Shared header (mfp_seven_segment.vh): SEG_OFF=7'h7F and the 16 hex encodings as localparam constants.
- Sub-module: mfp_hex_to_seven_segment. Purely combinational nibble to active-low 7-bit code, instantiated once on the muxed nibble.

Test Plan:
Bench parameters for all scenarios: N_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2.
1. Reset, no load, run 3 frames -> anodes stay 4'hF, segments 7'h7F, dp=1; frame_done pulses every 32 cycles; pending=0.
2. load with number=16'h8A10, digit_en=4'hF, dot_en=4'b0010 -> pending=1 until the boundary. Next frame:
   - digit0: anodes=4'b1110 in slot cycles 2..7, segments=1000000.
   - digit1: segments=1111001, dp=0.
   - digit2: segments=0001000.
   - digit3: segments=0000000.
3. digit_en=4'b0101 with a valid number -> digits 1 and 3 never drive an anode low; segments=7'h7F in those slots; the blank window p=0..1 is all-off in every slot.
4. Two loads in one frame (number 16'h1111 then 16'h2222) -> only 16'h2222 is ever displayed; 16'h1111 never appears.
5. load exactly on a frame boundary with a prior pending value -> the prior value is displayed next frame; pending stays 1; the new value appears the frame after.
6. rst pulse mid-slot while digit2 is lit -> anodes=4'hF within the reset assertion (async); after release, the display stays blank and idx restarts at 0.

Source files
------------

// File: rtl/mfp_seven_segment_pkg.sv
// Shared constants for the seven-segment display path: the all-off pattern and
// the active-low hex glyphs, bit order g..a (bit0 = segment a).
package mfp_seven_segment_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [6:0] HEX_0 = 7'b1000000;
    localparam logic [6:0] HEX_1 = 7'b1111001;
    localparam logic [6:0] HEX_2 = 7'b0100100;
    localparam logic [6:0] HEX_3 = 7'b0110000;
    localparam logic [6:0] HEX_4 = 7'b0011001;
    localparam logic [6:0] HEX_5 = 7'b0010010;
    localparam logic [6:0] HEX_6 = 7'b0000010;
    localparam logic [6:0] HEX_7 = 7'b1111000;
    localparam logic [6:0] HEX_8 = 7'b0000000;
    localparam logic [6:0] HEX_9 = 7'b0010000;
    localparam logic [6:0] HEX_A = 7'b0001000;
    localparam logic [6:0] HEX_B = 7'b0000011;
    localparam logic [6:0] HEX_C = 7'b1000110;
    localparam logic [6:0] HEX_D = 7'b0100001;
    localparam logic [6:0] HEX_E = 7'b0000110;
    localparam logic [6:0] HEX_F = 7'b0001110;

endpackage

// File: rtl/mfp_hex_to_seven_segment.sv
// Combinational hex nibble to active-low seven-segment glyph.
module mfp_hex_to_seven_segment
    import mfp_seven_segment_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segments
);

    // Glyph lookup; every nibble value has a glyph.
    always_comb begin
        segments = SEG_OFF;
        case (nibble)
            4'h0: segments = HEX_0;
            4'h1: segments = HEX_1;
            4'h2: segments = HEX_2;
            4'h3: segments = HEX_3;
            4'h4: segments = HEX_4;
            4'h5: segments = HEX_5;
            4'h6: segments = HEX_6;
            4'h7: segments = HEX_7;
            4'h8: segments = HEX_8;
            4'h9: segments = HEX_9;
            4'hA: segments = HEX_A;
            4'hB: segments = HEX_B;
            4'hC: segments = HEX_C;
            4'hD: segments = HEX_D;
            4'hE: segments = HEX_E;
            4'hF: segments = HEX_F;
            default: segments = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/mfp_seven_segment_scanner.sv
// Time-multiplexed common-anode seven-segment scanner with per-digit blanking,
// an all-off blank window at the start of each slot to suppress ghosting, and
// a pending shadow register so new values only take effect on a frame boundary.
module mfp_seven_segment_scanner
    import mfp_seven_segment_pkg::*;
#(
    parameter int N_DIGITS     = 8,
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*N_DIGITS-1:0]   number,
    input  logic [N_DIGITS-1:0]     dot_en,
    input  logic [N_DIGITS-1:0]     digit_en,
    input  logic                    load,
    output logic                    pending,
    output logic                    frame_done,
    output logic [6:0]              segments,
    output logic                    dp,
    output logic [N_DIGITS-1:0]     anodes
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    // The slot timer counts down: remaining = SCAN_DIV-1-p, so p==0 reloads
    // to SLOT_LAST and the slot ends at terminal count zero. The blank window
    // p < BLANK_CYCLES is therefore remaining > LIT_LIMIT.
    localparam logic [PW-1:0] SLOT_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] LIT_LIMIT = PW'(SCAN_DIV - 1 - BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);

    logic [PW-1:0]           slot_cnt;
    logic [IW-1:0]           idx;

    logic [4*N_DIGITS-1:0]   act_number;
    logic [N_DIGITS-1:0]     act_dot;
    logic [N_DIGITS-1:0]     act_en;
    logic [4*N_DIGITS-1:0]   pend_number;
    logic [N_DIGITS-1:0]     pend_dot;
    logic [N_DIGITS-1:0]     pend_en;

    logic                    slot_end;
    logic                    frame_end;
    logic                    digit_lit;
    logic [4*N_DIGITS-1:0]   number_sh;
    logic [N_DIGITS-1:0]     dot_sh;
    logic [N_DIGITS-1:0]     en_sh;
    logic [3:0]              cur_nibble;
    logic [6:0]              cur_glyph;
    logic [N_DIGITS-1:0]     anode_sel;

    logic [N_DIGITS-1:0]     anodes_nxt;
    logic [6:0]              segments_nxt;
    logic                    dp_nxt;

    assign slot_end  = (slot_cnt == '0);
    assign frame_end = slot_end && (idx == IDX_LAST);

    // Shifting rather than indexing keeps the select legal for any N_DIGITS,
    // including a single digit where idx carries no information.
    assign number_sh  = act_number >> {idx, 2'b00};
    assign dot_sh     = act_dot >> idx;
    assign en_sh      = act_en >> idx;
    assign cur_nibble = number_sh[3:0];
    assign anode_sel  = N_DIGITS'(1) << idx;
    assign digit_lit  = (slot_cnt <= LIT_LIMIT) && en_sh[0];

    mfp_hex_to_seven_segment u_hex (
        .nibble   (cur_nibble),
        .segments (cur_glyph)
    );

    // Next output pattern for the current slot position; everything off unless lit.
    always_comb begin
        anodes_nxt   = '1;
        segments_nxt = SEG_OFF;
        dp_nxt       = 1'b1;
        if (digit_lit) begin
            anodes_nxt   = ~anode_sel;
            segments_nxt = cur_glyph;
            dp_nxt       = ~dot_sh[0];
        end
    end

    // Slot timer and digit index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_cnt <= SLOT_LAST;
            idx      <= '0;
        end else if (slot_end) begin
            slot_cnt <= SLOT_LAST;
            idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            slot_cnt <= slot_cnt - 1'b1;
        end
    end

    // Shadow capture: a load always lands in pending (latest wins); the
    // previously pending value is promoted to active at the frame boundary,
    // even when a new load arrives in that same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_number <= '0;
            pend_dot    <= '0;
            pend_en     <= '0;
            pending     <= 1'b0;
            act_number  <= '0;
            act_dot     <= '0;
            act_en      <= '0;
        end else begin
            if (frame_end && pending) begin
                act_number <= pend_number;
                act_dot    <= pend_dot;
                act_en     <= pend_en;
            end
            if (load) begin
                pend_number <= number;
                pend_dot    <= dot_en;
                pend_en     <= digit_en;
                pending     <= 1'b1;
            end else if (frame_end) begin
                pending     <= 1'b0;
            end
        end
    end

    // Registered display outputs and the end-of-frame pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            anodes     <= '1;
            segments   <= SEG_OFF;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            anodes     <= anodes_nxt;
            segments   <= segments_nxt;
            dp         <= dp_nxt;
            frame_done <= frame_end;
        end
    end

endmodule

// File: tb/tb_mfp_seven_segment_scanner.sv
// Directed bench for the seven-segment scanner: 4 digits, 8-cycle slots,
// 2-cycle blank window, so one frame is 32 clocks.
module tb_mfp_seven_segment_scanner;

    logic        clk;
    logic        rst;
    logic [15:0] number;
    logic [3:0]  dot_en;
    logic [3:0]  digit_en;
    logic        load;
    logic        pending;
    logic        frame_done;
    logic [6:0]  segments;
    logic        dp;
    logic [3:0]  anodes;

    int n_asserts = 0;
    int n_fail    = 0;

    // Expected on-screen content for the frame being checked.
    logic [6:0] e_seg [4];
    logic [3:0] e_dot;
    logic [3:0] e_en;

    // Load schedule for the frame being checked (slot-relative cycle, -1 = none).
    int          ld_at0 = -1;
    int          ld_at1 = -1;
    logic [15:0] ld_num0, ld_num1;
    logic [3:0]  ld_dot0, ld_dot1;
    logic [3:0]  ld_en0,  ld_en1;

    mfp_seven_segment_scanner #(
        .N_DIGITS     (4),
        .SCAN_DIV     (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .number     (number),
        .dot_en     (dot_en),
        .digit_en   (digit_en),
        .load       (load),
        .pending    (pending),
        .frame_done (frame_done),
        .segments   (segments),
        .dp         (dp),
        .anodes     (anodes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_exp(input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input logic [6:0] s3,
                           input logic [3:0] dots, input logic [3:0] ens);
        e_seg[0] = s0;
        e_seg[1] = s1;
        e_seg[2] = s2;
        e_seg[3] = s3;
        e_dot    = dots;
        e_en     = ens;
    endtask

    // Runs one 32-cycle frame from a frame boundary. After the edge that
    // processes slot position s, the outputs reflect s. pend_exp[s] is the
    // expected pending flag after that edge.
    task automatic check_frame(input string name, input logic [31:0] pend_exp);
        int         p, d;
        logic       lit;
        logic [3:0] x_an;
        logic [6:0] x_seg;
        logic       x_dp;
        for (int s = 0; s < 32; s++) begin
            if (s == ld_at0) begin
                number = ld_num0; dot_en = ld_dot0; digit_en = ld_en0; load = 1'b1;
            end else if (s == ld_at1) begin
                number = ld_num1; dot_en = ld_dot1; digit_en = ld_en1; load = 1'b1;
            end
            step();
            if (load) begin
                load     = 1'b0;
                number   = 16'h0000;
                dot_en   = 4'hF;
                digit_en = 4'hF;
            end
            p     = s % 8;
            d     = s / 8;
            lit   = (p >= 2) && e_en[d];
            x_an  = lit ? ~(4'b0001 << d) : 4'hF;
            x_seg = lit ? e_seg[d] : 7'h7F;
            x_dp  = lit ? ~e_dot[d] : 1'b1;
            chk($sformatf("%s s%0d anodes", name, s), {12'h0, anodes}, {12'h0, x_an});
            chk($sformatf("%s s%0d segments", name, s), {9'h0, segments}, {9'h0, x_seg});
            chk($sformatf("%s s%0d dp", name, s), {15'h0, dp}, {15'h0, x_dp});
            chk($sformatf("%s s%0d frame_done", name, s), {15'h0, frame_done},
                {15'h0, (s == 31)});
            chk($sformatf("%s s%0d pending", name, s), {15'h0, pending},
                {15'h0, pend_exp[s]});
        end
        ld_at0 = -1;
        ld_at1 = -1;
    endtask

    initial begin
        rst      = 1'b1;
        number   = 16'h0000;
        dot_en   = 4'h0;
        digit_en = 4'h0;
        load     = 1'b0;

        // Reset state.
        step();
        step();
        chk("reset anodes", {12'h0, anodes}, 16'h000F);
        chk("reset segments", {9'h0, segments}, 16'h007F);
        chk("reset dp", {15'h0, dp}, 16'h0001);
        chk("reset frame_done", {15'h0, frame_done}, 16'h0000);
        chk("reset pending", {15'h0, pending}, 16'h0000);
        rst = 1'b0;

        // Three blank frames with nothing loaded.
        set_exp(7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'h0, 4'h0);
        check_frame("idle0", 32'h0);
        check_frame("idle1", 32'h0);
        check_frame("idle2", 32'h0);

        // Load 8A10 on the first cycle of a frame; it waits for the boundary.
        ld_at0 = 0; ld_num0 = 16'h8A10; ld_dot0 = 4'b0010; ld_en0 = 4'hF;
        check_frame("pend8A10", 32'h7FFF_FFFF);
        set_exp(7'h40, 7'h79, 7'h08, 7'h00, 4'b0010, 4'hF);
        check_frame("show8A10", 32'h0);

        // Digits 1 and 3 disabled.
        ld_at0 = 5; ld_num0 = 16'h3456; ld_dot0 = 4'hF; ld_en0 = 4'b0101;
        check_frame("pend3456", 32'h7FFF_FFE0);
        set_exp(7'h02, 7'h12, 7'h19, 7'h30, 4'hF, 4'b0101);
        check_frame("show3456", 32'h0);

        // Two loads in one frame: the later one wins.
        ld_at0 = 3;  ld_num0 = 16'h1111; ld_dot0 = 4'h0; ld_en0 = 4'hF;
        ld_at1 = 20; ld_num1 = 16'h2222; ld_dot1 = 4'h0; ld_en1 = 4'hF;
        check_frame("pend2222", 32'h7FFF_FFF8);
        set_exp(7'h24, 7'h24, 7'h24, 7'h24, 4'h0, 4'hF);
        check_frame("show2222", 32'h0);

        // Load on the boundary cycle while C0DE is still pending.
        ld_at0 = 10; ld_num0 = 16'hC0DE; ld_dot0 = 4'b0001; ld_en0 = 4'hF;
        ld_at1 = 31; ld_num1 = 16'h7B9F; ld_dot1 = 4'b1000; ld_en1 = 4'b1110;
        check_frame("pendC0DE", 32'hFFFF_FC00);
        set_exp(7'h06, 7'h21, 7'h40, 7'h46, 4'b0001, 4'hF);
        check_frame("showC0DE", 32'h7FFF_FFFF);
        set_exp(7'h0E, 7'h10, 7'h03, 7'h78, 4'b1000, 4'b1110);
        check_frame("show7B9F", 32'h0);

        // Mid-slot reset while digit 2 is lit (slot position 19).
        for (int i = 0; i < 20; i++) step();
        chk("prereset anodes", {12'h0, anodes}, 16'h000B);
        chk("prereset segments", {9'h0, segments}, 16'h0003);
        rst = 1'b1;
        #1;
        chk("async anodes", {12'h0, anodes}, 16'h000F);
        chk("async segments", {9'h0, segments}, 16'h007F);
        chk("async dp", {15'h0, dp}, 16'h0001);
        chk("async pending", {15'h0, pending}, 16'h0000);
        step();
        step();
        rst = 1'b0;
        set_exp(7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'h0, 4'h0);
        check_frame("postrst", 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
